// File: rtl/ysyx_25050136_axi_pkg.sv
// Shared AXI4 encodings for the SRAM slave: response codes, burst types and
// the read/write channel FSM state encodings.
package ysyx_25050136_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/ysyx_25050136_axi_burst_addr.sv
// Combinational AXI4 burst address stepper: computes the address of the
// following beat and flags burst encodings this slave cannot serve.
module ysyx_25050136_axi_burst_addr
  import ysyx_25050136_axi_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o,
  output logic        burst_err_o
);

  logic [31:0] incr;
  logic [31:0] wrap_mask;
  logic [31:0] seq_addr;
  logic        wrap_len_ok;

  always_comb begin
    incr        = 32'd1 << size_i;
    // WRAP container is (len+1) beats of 2^size bytes, aligned to its own size.
    wrap_mask   = (({24'd0, len_i} + 32'd1) << size_i) - 32'd1;
    seq_addr    = addr_i + incr;
    wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    burst_err_o = (size_i > 3'd2) || (burst_i == 2'b11) ||
                  ((burst_i == BURST_WRAP) && !wrap_len_ok);
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (seq_addr & wrap_mask);
      default:     next_addr_o = seq_addr;
    endcase
  end

endmodule

// File: rtl/ysyx_25050136_axi_sram_slave.sv
// AXI4 slave backed by a word-addressed SRAM; independent read and write FSMs,
// one outstanding transaction per direction, per-beat SLVERR checking.
module ysyx_25050136_axi_sram_slave
  import ysyx_25050136_axi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awid_i,
  input  logic [7:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o,
  output logic [3:0]  bid_o,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arid_i,
  input  logic [7:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic [3:0]  rid_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (IDX_W + 2)) == 32'd0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds valid and payload stable until that edge.
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // ---------------- write channel ----------------
  w_state_e    w_state_q, w_state_d;
  logic [31:0] aw_addr_q, aw_next;
  logic [7:0]  aw_len_q, w_cnt_q;
  logic [2:0]  aw_size_q;
  logic [1:0]  aw_burst_q, bresp_q;
  logic [3:0]  aw_id_q;
  logic        w_err_q, aw_burst_err, w_beat_err, w_last_beat;

  assign awready_o = (w_state_q == W_IDLE);
  assign wready_o  = (w_state_q == W_DATA);
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bresp_o   = bresp_q;
  assign bid_o     = aw_id_q;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  assign b_hs      = bvalid_o && bready_i;

  ysyx_25050136_axi_burst_addr u_aw_addr (
    .addr_i      (aw_addr_q),
    .len_i       (aw_len_q),
    .size_i      (aw_size_q),
    .burst_i     (aw_burst_q),
    .next_addr_o (aw_next),
    .burst_err_o (aw_burst_err)
  );

  assign w_beat_err  = aw_burst_err || !in_range(aw_addr_q);
  assign w_last_beat = (w_cnt_q == aw_len_q);

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= BURST_FIXED;
      aw_id_q    <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        aw_addr_q  <= awaddr_i;
        aw_len_q   <= awlen_i;
        aw_size_q  <= awsize_i;
        aw_burst_q <= awburst_i;
        aw_id_q    <= awid_i;
        w_cnt_q    <= '0;
        w_err_q    <= 1'b0;
      end
      if (w_hs) begin
        aw_addr_q <= aw_next;
        w_cnt_q   <= w_cnt_q + 8'd1;
        // The beat counter ends the burst; a disagreeing wlast only poisons bresp.
        if (w_last_beat)
          bresp_q <= (w_err_q || w_beat_err || !wlast_i) ? RESP_SLVERR : RESP_OKAY;
        else
          w_err_q <= w_err_q || w_beat_err || wlast_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_hs && !w_beat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[word_idx(aw_addr_q)][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e    r_state_q, r_state_d;
  logic [31:0] ar_addr_q, ar_next, ar_cur_addr, rdata_q;
  logic [7:0]  ar_len_q, ar_cur_len, r_cnt_q;
  logic [2:0]  ar_size_q, ar_cur_size;
  logic [1:0]  ar_burst_q, ar_cur_burst, rresp_q;
  logic [3:0]  rid_q;
  logic        rlast_q, ar_burst_err, r_beat_err, r_idle, r_fetch;

  assign r_idle    = (r_state_q == R_IDLE);
  assign arready_o = r_idle;
  assign rvalid_o  = (r_state_q == R_DATA);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;
  assign rid_o     = rid_q;
  assign ar_hs     = arvalid_i && arready_o;
  assign r_hs      = rvalid_o && rready_i;

  // While idle the stepper looks at the incoming AR so beat 0 is fetched on the
  // handshake edge; afterwards it steps the latched address of the next beat.
  assign ar_cur_addr  = r_idle ? araddr_i  : ar_addr_q;
  assign ar_cur_len   = r_idle ? arlen_i   : ar_len_q;
  assign ar_cur_size  = r_idle ? arsize_i  : ar_size_q;
  assign ar_cur_burst = r_idle ? arburst_i : ar_burst_q;

  ysyx_25050136_axi_burst_addr u_ar_addr (
    .addr_i      (ar_cur_addr),
    .len_i       (ar_cur_len),
    .size_i      (ar_cur_size),
    .burst_i     (ar_cur_burst),
    .next_addr_o (ar_next),
    .burst_err_o (ar_burst_err)
  );

  assign r_beat_err = ar_burst_err || !in_range(ar_cur_addr);
  assign r_fetch    = ar_hs || (r_hs && !rlast_q);

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= BURST_FIXED;
      r_cnt_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        ar_len_q   <= arlen_i;
        ar_size_q  <= arsize_i;
        ar_burst_q <= arburst_i;
        rid_q      <= arid_i;
        r_cnt_q    <= '0;
        rlast_q    <= (arlen_i == 8'd0);
      end else if (r_hs) begin
        r_cnt_q <= r_cnt_q + 8'd1;
        rlast_q <= !rlast_q && ((r_cnt_q + 8'd1) == ar_len_q);
      end
      if (r_fetch) begin
        ar_addr_q <= ar_next;
        rdata_q   <= r_beat_err ? 32'h0 : mem_q[word_idx(ar_cur_addr)];
        rresp_q   <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: doc/ysyx_25050136_axi_sram_slave.md
# ysyx_25050136_axi_sram_slave

AXI4 slave responder backed by an internal word-addressed SRAM array. It terminates the AXI4 master traffic that the CPU top and its read arbiter produce, including INCR, FIXED and WRAP bursts, narrow sizes and byte strobes. It serves as the on-chip scratch memory behind the SoC slave port and as the standalone simulation memory for the NPC bench. Read and write channels run independent FSMs, with at most one outstanding transaction per direction.

## Interface
- DEPTH_WORDS, 1024: SRAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- awvalid_i / awready_o  in/out  1/1  write-address handshake.
- awaddr_i, awid_i, awlen_i, awsize_i, awburst_i  in  32/4/8/3/2  write-address payload.
- wvalid_i / wready_o  in/out  1/1  write-data handshake.
- wdata_i, wstrb_i, wlast_i  in  32/4/1  write-data payload.
- bvalid_o / bready_i  out/in  1/1  write-response handshake.
- bresp_o, bid_o  out  2/4  write response; bid_o echoes the latched awid_i.
- arvalid_i / arready_o  in/out  1/1  read-address handshake.
- araddr_i, arid_i, arlen_i, arsize_i, arburst_i  in  32/4/8/3/2  read-address payload.
- rvalid_o / rready_i  out/in  1/1  read-data handshake.
- rdata_o, rresp_o, rlast_o, rid_o  out  32/2/1/4  read-data payload; rid_o echoes the latched arid_i.

## Operation
- Write FSM: W_IDLE (awready_o=1) → W_DATA on AW handshake (wready_o=1) → W_RESP after the beat with beat count == awlen (bvalid_o=1) → W_IDLE on B handshake.
- Read FSM: R_IDLE (arready_o=1) → R_DATA on AR handshake (rvalid_o=1) → R_IDLE on handshake of the beat with count == arlen.
- Word index = (addr − BASE_ADDR) >> 2.
- Next address:
  - FIXED: unchanged.
  - INCR: addr + (1 << size).
  - WRAP: increments, then wraps inside the block aligned to (len+1) << size.
- Each write beat updates only byte lanes with wstrb_i=1.
- Narrow reads return the full 32-bit word, lane-aligned.
- Per-beat error check; a failing beat yields resp 2'b10 (SLVERR), read data 32'h0, and no write. A beat fails when any of these holds:
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4);
  - size > 2;
  - burst == 2'b11;
  - WRAP with len not in {1,3,7,15}.
- Write response: bresp_o is SLVERR if any beat failed. It is also SLVERR if wlast_i disagrees with the internal beat counter. The counter alone decides when the burst ends.
- SRAM contents are not cleared by reset.

## Timing
- Reset values:
  - awready_o=1, arready_o=1.
  - wready_o, bvalid_o, rvalid_o, rlast_o = 0.
  - bresp_o, rresp_o, rdata_o, bid_o, rid_o = 0.
- A reset asserted mid-burst returns both FSMs to IDLE on that edge and abandons the burst. Write beats already committed stay written.
- Write path:
  - AW handshake at cycle N: wready_o=1 from N+1.
  - A beat is written on its W handshake edge.
  - The last beat is accepted at cycle M: bvalid_o=1 from M+1 and held until bready_i.
  - awready_o returns the cycle after the B handshake.
- Read path:
  - AR handshake at cycle N: rvalid_o=1 with beat 0 at N+1 (registered SRAM read).
  - Throughput is one beat per cycle with rready_i held high.
  - rdata_o, rresp_o and rlast_o are held stable while rvalid_o=1 and rready_i=0.
  - rlast_o=1 only on beat arlen.
  - arready_o returns the cycle after the last R handshake.
- Read and write to the same word on the same edge: the read captures the old data.
- AW and AR handshakes may occur in the same cycle; the two FSMs proceed independently.

## Structure
- Shared package ysyx_25050136_axi_pkg holds:
  - RESP_OKAY/RESP_SLVERR/RESP_DECERR;
  - BURST_FIXED/INCR/WRAP;
  - read and write FSM state encodings.
- Sub-module ysyx_25050136_axi_burst_addr is combinational and is instantiated twice, once for AW and once for AR.
  - Inputs: addr, len, size, burst.
  - Outputs: next_addr, burst_err.

## Test plan
- Single write, BASE+0x10, len 0, size 2, data 32'hDEADBEEF, strb 4'hF, awid 4'h3 → bresp 2'b00, bid 4'h3. Read back → rdata 32'hDEADBEEF, rlast 1, rresp 2'b00.
- INCR write, len 3, data 1,2,3,4 at BASE+0x20. Read back with rready toggling every cycle → 1,2,3,4 in order, data held while stalled, rlast on the 4th beat only.
- WRAP read, len 3, size 2, start BASE+0x28 → words from 0x28, 0x2C, 0x20, 0x24.
- Word holds 32'h11223344; write 32'h000000AA with strb 4'h1 → read returns 32'h112233AA.
- Read at BASE+DEPTH_WORDS*4, len 1 → two beats, rresp 2'b10, rdata 0. A write to the same address → bresp 2'b10, and memory is unchanged.
- Reset asserted during beat 2 of a len-7 read → next cycle rvalid_o=0 and arready_o=1. A subsequent read still returns the pre-reset contents.
